mac16q9_seq: RTL and testbench

MAC16Q9_SEQ -- requirements
Module: mac16q9_seq

---
 rtl/mac16q9_seq.sv | 78 +++++++
 tb/tb_mac16q9_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mac16q9_seq.sv
// mac16q9_seq: sequential Q9 dot-product MAC with round-to-nearest and saturation.
// Define MAC16Q9_SEQ_BIAS_EN to add bias_i as the initial accumulator value.
module mac16q9_seq (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  len_i,
    input  logic [15:0] a_i,
    input  logic [15:0] x_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        y_valid_o,
    input  logic        y_ready_i,
    output logic [15:0] y_sat_o,
    output logic [35:0] y_ori_o,
    output logic        sat_o,
    output logic        busy_o
`ifdef MAC16Q9_SEQ_BIAS_EN
    ,
    input  logic [35:0] bias_i
`endif
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t      state_q, state_d;
    logic [35:0] acc_q, acc_d, init;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] prod;
    logic [27:0] rnd;
    logic        carry, hi, lo, done;
`ifdef MAC16Q9_SEQ_BIAS_EN
    assign init = bias_i;
`else
    assign init = '0;
`endif
    assign prod = $signed(a_i) * $signed(x_i);
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d = ACC;
                acc_d   = init;
                cnt_d   = len_i;
            end
            ACC: if (in_valid_i) begin
                acc_d   = acc_q + {{4{prod[31]}}, prod};
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? DONE : ACC;
            end
            DONE: if (y_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end
    // ties round toward zero: negative values always carry on bit 8
    assign carry = acc_q[35] ? acc_q[8] : (acc_q[8] & |acc_q[7:0]);
    assign rnd   = {acc_q[35], acc_q[35:9]} + {27'd0, carry};
    assign hi    = !rnd[27] && |rnd[26:15];
    assign lo    = rnd[27] && !(&rnd[26:15]);
    assign done  = (state_q == DONE);
    assign y_valid_o  = done;
    assign in_ready_o = (state_q == ACC);
    assign busy_o     = (state_q != IDLE);
    assign y_ori_o    = done ? acc_q : '0;
    assign sat_o      = done & (hi | lo);
    assign y_sat_o    = !done ? '0 : hi ? 16'h7fff : lo ? 16'h8000 : rnd[15:0];
endmodule

// File: tb/tb_mac16q9_seq.sv
// tb_mac16q9_seq: table-driven and sequence checks of mac16q9_seq with a result scoreboard.
module tb_mac16q9_seq;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, y_ready;
    logic [3:0]  len;
    logic [15:0] a, x, y_sat;
    logic [35:0] y_ori, bias;
    logic        in_ready, y_valid, sat, busy;
    always #5 clk = ~clk;
    mac16q9_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
        .a_i(a), .x_i(x), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .y_valid_o(y_valid), .y_ready_i(y_ready), .y_sat_o(y_sat),
        .y_ori_o(y_ori), .sat_o(sat), .busy_o(busy)
`ifdef MAC16Q9_SEQ_BIAS_EN
        , .bias_i(bias)
`endif
    );
    typedef struct {logic [35:0] ori; logic [15:0] y; logic s;} exp_t;
    typedef struct {logic [15:0] a; logic [15:0] x; exp_t e;} vec_t;
    exp_t        sb[$];
    vec_t        tbl[10];
    logic [15:0] va[16], vx[16];
    int          total = 0, bad = 0, stalls;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, expv);
        end
    endtask

    task automatic feed(input int n, input logic [3:0] l, input bit gaps);
        int t;
        stalls = 0;
        @(posedge clk); #1 start = 1; len = l;
        @(posedge clk); #1 start = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1; a = va[i]; x = vx[i]; t = 0;
            while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
            stalls += t;
            @(posedge clk); #1;
            if (gaps && i < n - 1) begin
                in_valid = 0; a = 16'h7fff; x = 16'h7fff;
                @(posedge clk); #1;
            end
        end
        in_valid = 0;
        chk("valid_latency", {63'd0, y_valid}, 64'd1);
        t = 0;
        while (!y_valid && t < 20) begin @(posedge clk); #1; t++; end
    endtask

    task automatic drain(input int hold, input bit pulse);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        chk("y_ori", {28'd0, y_ori}, {28'd0, e.ori});
        chk("y_sat", {48'd0, y_sat}, {48'd0, e.y});
        chk("sat", {63'd0, sat}, {63'd0, e.s});
        for (int i = 0; i < hold; i++) begin
            y_ready = 0; start = pulse;
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, y_valid}, 64'd1);
            chk("hold_ori", {28'd0, y_ori}, {28'd0, e.ori});
            chk("hold_y", {47'd0, sat, y_sat}, {47'd0, e.s, e.y});
        end
        y_ready = 1; start = pulse;
        @(posedge clk); #1;
        y_ready = 0; start = 0;
        chk("post_valid", {63'd0, y_valid}, 64'd0);
        chk("post_busy", {63'd0, busy}, 64'd0);
        chk("post_ori", {28'd0, y_ori}, 64'd0);
        chk("post_ysat", {47'd0, sat, y_sat}, 64'd0);
    endtask

    task automatic chk_idle(input string n);
        chk(n, {59'd0, in_ready, y_valid, sat, busy, |y_sat, |y_ori}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'd512,   16'd512,   '{36'd262144,      16'd512,   1'b0}};
        tbl[1] = '{16'd1,     16'd256,   '{36'd256,         16'd0,     1'b0}};
        tbl[2] = '{16'hffff,  16'd256,   '{36'hffffff00,    16'd0,     1'b0}};
        tbl[3] = '{16'd1,     16'd257,   '{36'd257,         16'd1,     1'b0}};
        tbl[4] = '{16'hfe00,  16'd512,   '{36'hffffc0000,   16'hfe00,  1'b0}};
        tbl[5] = '{16'h7fff,  16'h7fff,  '{36'h3fff0001,    16'h7fff,  1'b1}};
        tbl[6] = '{16'h8000,  16'h7fff,  '{36'hfc0008000,   16'h8000,  1'b1}};
        tbl[7] = '{16'd768,   16'd1,     '{36'd768,         16'd1,     1'b0}};
        tbl[8] = '{16'hfd00,  16'd1,     '{36'hffffffd00,   16'hffff,  1'b0}};
        tbl[9] = '{16'd100,   16'd300,   '{36'd30000,       16'd59,    1'b0}};
        tbl[2].e.ori = 36'hfffffff00;
        rst = 1; start = 0; in_valid = 0; y_ready = 0; len = 0; a = 0; x = 0; bias = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset_outputs");
        chk("reset_busy", {63'd0, busy}, 64'd0);
        rst = 0;
        in_valid = 1; a = 16'h7fff; x = 16'h7fff;
        #1 chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1 in_valid = 0;
        chk_idle("idle_ignore_terms");
        for (int i = 0; i < 10; i++) begin
            va[0] = tbl[i].a; vx[0] = tbl[i].x;
            sb.push_back(tbl[i].e);
            feed(1, 4'd0, 1'b0);
            drain(0, 1'b0);
        end
        for (int i = 0; i < 16; i++) begin va[i] = 16'h8000; vx[i] = 16'h8000; end
        sb.push_back('{36'h400000000, 16'h7fff, 1'b1});
        feed(16, 4'd15, 1'b0);
        chk("no_bubbles", 64'(stalls), 64'd0);
        drain(0, 1'b0);
        va[0] = 16'd512;  vx[0] = 16'd512;
        va[1] = 16'd512;  vx[1] = 16'd1024;
        va[2] = 16'hfe00; vx[2] = 16'd512;
        va[3] = 16'd100;  vx[3] = 16'd300;
        sb.push_back('{36'h87530, 16'd1083, 1'b0});
        feed(4, 4'd3, 1'b1);
        drain(5, 1'b1);
        @(posedge clk); #1 start = 1; len = 4'd3;
        @(posedge clk); #1 start = 0; in_valid = 1; a = 16'd512; x = 16'd512;
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 0; rst = 1;
        @(posedge clk); #1 rst = 0;
        chk_idle("mid_reset_outputs");
        chk("mid_reset_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_idle("after_reset_quiet");
        end
        va[0] = 16'd512; vx[0] = 16'd512;
        sb.push_back('{36'd262144, 16'd512, 1'b0});
        feed(1, 4'd0, 1'b0);
        drain(0, 1'b0);
`ifdef MAC16Q9_SEQ_BIAS_EN
        bias = 36'hffffc0000;
        sb.push_back('{36'd0, 16'd0, 1'b0});
        feed(1, 4'd0, 1'b0);
        drain(0, 1'b0);
        bias = 0;
`endif
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
